// File: rtl/br_resolve_pkg.sv
// Shared types, widths and the ROB age-compare helper for the branch resolution stage.
package br_resolve_pkg;

  localparam int MAX_BR = 20;
  localparam int ROB_W  = 7;
  localparam int TAG_W  = 5;
  localparam int OFF_W  = 21;

  typedef struct packed {
    logic                    valid;
    logic                    mispredict;
    logic                    taken;
    logic [TAG_W-1:0]        tag;
    logic [ROB_W-1:0]        rob_idx;
    logic [2:0]              cfi_type;
    logic [1:0]              pc_sel;
    logic signed [OFF_W-1:0] target_offset;
  } br_info_t;

  typedef enum logic {IDLE, PEND} redir_state_e;

  // Age is the distance from the ROB head, modulo the ROB size.
  function automatic logic is_older(input logic [ROB_W-1:0] a,
                                    input logic [ROB_W-1:0] b,
                                    input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] dist_a;
    logic [ROB_W-1:0] dist_b;
    dist_a = a - head;
    dist_b = b - head;
    return dist_a < dist_b;
  endfunction

endpackage

// File: rtl/br_resolve_unit_age_select.sv
// Combinational picker: oldest candidate by ROB age, lowest source index on a tie.
module br_age_select
  import br_resolve_pkg::*;
#(
  parameter int NUM_BR = 2,
  parameter int IDX_W  = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
  input  logic [NUM_BR-1:0]       cand,
  input  logic [NUM_BR*ROB_W-1:0] rob_idx,
  input  logic [ROB_W-1:0]        head,
  output logic [IDX_W-1:0]        sel,
  output logic                    found
);

  logic [ROB_W-1:0] best;
  logic [ROB_W-1:0] cur;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    best  = '0;
    cur   = '0;
    for (int unsigned i = 0; i < NUM_BR; i++) begin
      cur = rob_idx[i*ROB_W +: ROB_W];
      // Strictly-older replacement keeps the lowest index on ties.
      if (cand[i] && (!found || is_older(cur, best, head))) begin
        found = 1'b1;
        sel   = IDX_W'(i);
        best  = cur;
      end
    end
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolution: b1 masks (comb), b2 oldest-mispredict register, held frontend redirect.
module br_resolve_unit
  import br_resolve_pkg::*;
#(
  parameter int NUM_BR = 2,
  parameter int MAX_BR = br_resolve_pkg::MAX_BR,
  parameter int ROB_W  = br_resolve_pkg::ROB_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_BR-1:0]         br_valid,
  input  logic [NUM_BR-1:0]         br_mispredict,
  input  logic [NUM_BR-1:0]         br_taken,
  input  logic [NUM_BR*5-1:0]       br_tag,
  input  logic [NUM_BR*ROB_W-1:0]   br_rob_idx,
  input  logic [NUM_BR*3-1:0]       br_cfi_type,
  input  logic [NUM_BR*2-1:0]       br_pc_sel,
  input  logic [NUM_BR*21-1:0]      br_target_offset,
  input  logic [ROB_W-1:0]          rob_head_idx,
  input  logic                      flush,
  output logic [MAX_BR-1:0]         b1_resolve_mask,
  output logic [MAX_BR-1:0]         b1_mispredict_mask,
  output logic                      b2_valid,
  output logic [ROB_W-1:0]          b2_rob_idx,
  output logic [4:0]                b2_br_tag,
  output logic                      b2_taken,
  output logic [2:0]                b2_cfi_type,
  output logic [1:0]                b2_pc_sel,
  output logic [20:0]               b2_target_offset,
  output logic                      redirect_valid,
  input  logic                      redirect_ready,
  output logic [ROB_W-1:0]          redirect_rob_idx,
  output logic [1:0]                redirect_pc_sel,
  output logic [20:0]               redirect_target_offset
);

  localparam int IDX_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

  br_info_t          info [NUM_BR];
  logic [NUM_BR-1:0] cand;
  logic [IDX_W-1:0]  sel;
  logic              found;
  redir_state_e      state_q, state_d;
  logic              load_redir;

  always_comb begin
    for (int unsigned i = 0; i < NUM_BR; i++) begin
      info[i].valid         = br_valid[i];
      info[i].mispredict    = br_mispredict[i];
      info[i].taken         = br_taken[i];
      info[i].tag           = br_tag[i*TAG_W +: TAG_W];
      info[i].rob_idx       = br_rob_idx[i*ROB_W +: ROB_W];
      info[i].cfi_type      = br_cfi_type[i*3 +: 3];
      info[i].pc_sel        = br_pc_sel[i*2 +: 2];
      info[i].target_offset = br_target_offset[i*OFF_W +: OFF_W];
      cand[i]               = br_valid[i] & br_mispredict[i];
    end
  end

  // Tags outside the mask space are dropped rather than aliased.
  always_comb begin
    b1_resolve_mask    = '0;
    b1_mispredict_mask = '0;
    for (int unsigned i = 0; i < NUM_BR; i++) begin
      if (info[i].valid && !flush && (int'(info[i].tag) < MAX_BR)) begin
        b1_resolve_mask[info[i].tag] = 1'b1;
        if (info[i].mispredict) b1_mispredict_mask[info[i].tag] = 1'b1;
      end
    end
  end

  br_age_select #(
    .NUM_BR (NUM_BR),
    .IDX_W  (IDX_W)
  ) u_age_select (
    .cand    (cand),
    .rob_idx (br_rob_idx),
    .head    (rob_head_idx),
    .sel     (sel),
    .found   (found)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b2_valid         <= 1'b0;
      b2_rob_idx       <= '0;
      b2_br_tag        <= '0;
      b2_taken         <= 1'b0;
      b2_cfi_type      <= '0;
      b2_pc_sel        <= '0;
      b2_target_offset <= '0;
    end else begin
      b2_valid <= found & ~flush;
      if (found) begin
        b2_rob_idx       <= info[sel].rob_idx;
        b2_br_tag        <= info[sel].tag;
        b2_taken         <= info[sel].taken;
        b2_cfi_type      <= info[sel].cfi_type;
        b2_pc_sel        <= info[sel].pc_sel;
        b2_target_offset <= info[sel].target_offset;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load_redir = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (b2_valid) begin
          state_d    = PEND;
          load_redir = 1'b1;
        end
        PEND: begin
          if (redirect_ready) begin
            if (b2_valid) load_redir = 1'b1;
            else          state_d    = IDLE;
          end else if (b2_valid && is_older(b2_rob_idx, redirect_rob_idx, rob_head_idx)) begin
            load_redir = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q                <= IDLE;
      redirect_rob_idx       <= '0;
      redirect_pc_sel        <= '0;
      redirect_target_offset <= '0;
    end else begin
      state_q <= state_d;
      if (load_redir) begin
        redirect_rob_idx       <= b2_rob_idx;
        redirect_pc_sel        <= b2_pc_sel;
        redirect_target_offset <= b2_target_offset;
      end
    end
  end

  assign redirect_valid = (state_q == PEND);

endmodule

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: mask table, directed corner sequences, random vs model.
module tb_br_resolve_unit;

  localparam int N = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  br_valid, br_mispredict, br_taken;
  logic [N*5-1:0]  br_tag;
  logic [N*7-1:0]  br_rob_idx;
  logic [N*3-1:0]  br_cfi_type;
  logic [N*2-1:0]  br_pc_sel;
  logic [N*21-1:0] br_target_offset;
  logic [6:0]    rob_head_idx;
  logic          flush, redirect_ready;
  logic [19:0]   b1_resolve_mask, b1_mispredict_mask;
  logic          b2_valid, b2_taken, redirect_valid;
  logic [6:0]    b2_rob_idx, redirect_rob_idx;
  logic [4:0]    b2_br_tag;
  logic [2:0]    b2_cfi_type;
  logic [1:0]    b2_pc_sel, redirect_pc_sel;
  logic [20:0]   b2_target_offset, redirect_target_offset;

  br_resolve_unit #(.NUM_BR(N), .MAX_BR(20), .ROB_W(7)) dut (
    .clock(clock), .reset(reset),
    .br_valid(br_valid), .br_mispredict(br_mispredict), .br_taken(br_taken),
    .br_tag(br_tag), .br_rob_idx(br_rob_idx), .br_cfi_type(br_cfi_type),
    .br_pc_sel(br_pc_sel), .br_target_offset(br_target_offset),
    .rob_head_idx(rob_head_idx), .flush(flush),
    .b1_resolve_mask(b1_resolve_mask), .b1_mispredict_mask(b1_mispredict_mask),
    .b2_valid(b2_valid), .b2_rob_idx(b2_rob_idx), .b2_br_tag(b2_br_tag),
    .b2_taken(b2_taken), .b2_cfi_type(b2_cfi_type), .b2_pc_sel(b2_pc_sel),
    .b2_target_offset(b2_target_offset),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_rob_idx(redirect_rob_idx), .redirect_pc_sel(redirect_pc_sel),
    .redirect_target_offset(redirect_target_offset)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic        m_b2v, m_b2_taken, m_pend;
  logic [6:0]  m_b2_rob, m_r_rob;
  logic [4:0]  m_b2_tag;
  logic [2:0]  m_b2_cfi;
  logic [1:0]  m_b2_pcs, m_r_pcs;
  logic [20:0] m_b2_off, m_r_off;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_b2v = 0; m_b2_taken = 0; m_pend = 0;
    m_b2_rob = 0; m_r_rob = 0; m_b2_tag = 0; m_b2_cfi = 0;
    m_b2_pcs = 0; m_r_pcs = 0; m_b2_off = 0; m_r_off = 0;
  endtask

  function automatic int age(input logic [6:0] a, input logic [6:0] h);
    return (((int'(a) - int'(h)) % 128) + 128) % 128;
  endfunction

  task automatic set_src(input int i, input logic v, input logic mp, input logic tk,
                         input logic [4:0] tag, input logic [6:0] rob,
                         input logic [2:0] cfi, input logic [1:0] pcs, input logic [20:0] off);
    br_valid[i] = v; br_mispredict[i] = mp; br_taken[i] = tk;
    br_tag[i*5 +: 5] = tag; br_rob_idx[i*7 +: 7] = rob;
    br_cfi_type[i*3 +: 3] = cfi; br_pc_sel[i*2 +: 2] = pcs;
    br_target_offset[i*21 +: 21] = off;
  endtask

  task automatic clear_inputs();
    br_valid = '0; br_mispredict = '0; br_taken = '0; br_tag = '0;
    br_rob_idx = '0; br_cfi_type = '0; br_pc_sel = '0; br_target_offset = '0;
    flush = 0; redirect_ready = 0; rob_head_idx = '0;
  endtask

  task automatic check_regs();
    chk("b2_valid", 64'(b2_valid), 64'(m_b2v));
    chk("b2_rob_idx", 64'(b2_rob_idx), 64'(m_b2_rob));
    chk("b2_br_tag", 64'(b2_br_tag), 64'(m_b2_tag));
    chk("b2_taken", 64'(b2_taken), 64'(m_b2_taken));
    chk("b2_cfi_type", 64'(b2_cfi_type), 64'(m_b2_cfi));
    chk("b2_pc_sel", 64'(b2_pc_sel), 64'(m_b2_pcs));
    chk("b2_target_offset", 64'(b2_target_offset), 64'(m_b2_off));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_pend));
    chk("redirect_rob_idx", 64'(redirect_rob_idx), 64'(m_r_rob));
    chk("redirect_pc_sel", 64'(redirect_pc_sel), 64'(m_r_pcs));
    chk("redirect_target_offset", 64'(redirect_target_offset), 64'(m_r_off));
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    logic [19:0] e_res, e_mp;
    int best;
    logic n_b2v, n_pend, ld;
    e_res = '0; e_mp = '0; best = -1;
    #1;
    for (int i = 0; i < N; i++) begin
      if (br_valid[i] && !flush) begin
        e_res = e_res | (20'd1 << br_tag[i*5 +: 5]);
        if (br_mispredict[i]) e_mp = e_mp | (20'd1 << br_tag[i*5 +: 5]);
      end
      if (br_valid[i] && br_mispredict[i])
        if (best < 0 || age(br_rob_idx[i*7 +: 7], rob_head_idx) < age(br_rob_idx[best*7 +: 7], rob_head_idx))
          best = i;
    end
    chk("b1_resolve_mask", 64'(b1_resolve_mask), 64'(e_res));
    chk("b1_mispredict_mask", 64'(b1_mispredict_mask), 64'(e_mp));
    n_b2v = (best >= 0) && !flush;
    ld = 0;
    n_pend = m_pend;
    if (flush) n_pend = 0;
    else if (!m_pend) begin
      if (m_b2v) begin n_pend = 1; ld = 1; end
    end else if (redirect_ready) begin
      if (m_b2v) ld = 1; else n_pend = 0;
    end else if (m_b2v && age(m_b2_rob, rob_head_idx) < age(m_r_rob, rob_head_idx)) ld = 1;
    @(posedge clock);
    #1;
    if (ld) begin m_r_rob = m_b2_rob; m_r_pcs = m_b2_pcs; m_r_off = m_b2_off; end
    m_pend = n_pend;
    m_b2v = n_b2v;
    if (best >= 0) begin
      m_b2_rob = br_rob_idx[best*7 +: 7]; m_b2_tag = br_tag[best*5 +: 5];
      m_b2_taken = br_taken[best]; m_b2_cfi = br_cfi_type[best*3 +: 3];
      m_b2_pcs = br_pc_sel[best*2 +: 2]; m_b2_off = br_target_offset[best*21 +: 21];
    end
    check_regs();
    @(negedge clock);
  endtask

  // Single mispredict on source 0 at head 0, everything else idle.
  task automatic mp_cycle(input logic [6:0] rob, input logic [4:0] tag, input logic rdy);
    clear_inputs();
    redirect_ready = rdy;
    set_src(0, 1, 1, 1, tag, rob, 3'd2, 2'd1, 21'(rob) + 21'h100);
    cycle();
  endtask

  task automatic idle_cycle(input logic rdy, input logic fl);
    clear_inputs();
    redirect_ready = rdy;
    flush = fl;
    cycle();
  endtask

  typedef struct {
    logic [1:0]  v, mp;
    logic [4:0]  t0, t1;
    logic        fl;
    logic [19:0] er, em;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{v:2'b01, mp:2'b01, t0:5'd3, t1:5'd0,  fl:0, er:20'h00008, em:20'h00008};
    tbl[1] = '{v:2'b11, mp:2'b00, t0:5'd0, t1:5'd19, fl:0, er:20'h80001, em:20'h00000};
    tbl[2] = '{v:2'b11, mp:2'b10, t0:5'd5, t1:5'd5,  fl:0, er:20'h00020, em:20'h00020};
    tbl[3] = '{v:2'b10, mp:2'b11, t0:5'd7, t1:5'd2,  fl:0, er:20'h00004, em:20'h00004};
    tbl[4] = '{v:2'b11, mp:2'b11, t0:5'd1, t1:5'd2,  fl:1, er:20'h00000, em:20'h00000};
    tbl[5] = '{v:2'b00, mp:2'b11, t0:5'd9, t1:5'd4,  fl:0, er:20'h00000, em:20'h00000};

    clear_inputs();
    model_reset();
    reset = 0;
    repeat (2) @(negedge clock);
    check_regs();
    reset = 1;
    @(negedge clock);

    // Mask table
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      redirect_ready = 1;
      flush = tbl[k].fl;
      for (int i = 0; i < N; i++)
        set_src(i, tbl[k].v[i], tbl[k].mp[i], 0, (i == 0) ? tbl[k].t0 : tbl[k].t1,
                7'(10 * (k + i + 1)), 3'(k), 2'(i), 21'(k * 77));
      #1;
      chk("tbl_resolve", 64'(b1_resolve_mask), 64'(tbl[k].er));
      chk("tbl_mispredict", 64'(b1_mispredict_mask), 64'(tbl[k].em));
      cycle();
    end
    idle_cycle(0, 1);

    // Single mispredict end to end
    clear_inputs();
    set_src(0, 1, 1, 0, 5'd3, 7'd10, 3'd1, 2'd2, 21'h1ffff0);
    #1;
    chk("single_mask", 64'(b1_mispredict_mask), 64'h8);
    cycle();
    chk("single_b2_valid", 64'(b2_valid), 64'd1);
    chk("single_b2_rob", 64'(b2_rob_idx), 64'd10);
    idle_cycle(0, 0);
    chk("single_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("single_redirect_rob", 64'(redirect_rob_idx), 64'd10);
    idle_cycle(1, 0);
    chk("single_accepted", 64'(redirect_valid), 64'd0);

    // Dual mispredict across ROB wrap
    clear_inputs();
    rob_head_idx = 7'd120;
    set_src(0, 1, 1, 0, 5'd1, 7'd5, 3'd1, 2'd1, 21'd5);
    set_src(1, 1, 1, 1, 5'd2, 7'd125, 3'd4, 2'd3, 21'd125);
    #1;
    chk("wrap_mask", 64'(b1_mispredict_mask), 64'h6);
    cycle();
    chk("wrap_b2_rob", 64'(b2_rob_idx), 64'd125);
    chk("wrap_b2_tag", 64'(b2_br_tag), 64'd2);
    idle_cycle(0, 1);

    // Older replacement while held, younger does not replace
    mp_cycle(7'd40, 5'd4, 0);
    idle_cycle(0, 0);
    chk("repl_hold40", 64'(redirect_rob_idx), 64'd40);
    mp_cycle(7'd30, 5'd5, 0);
    idle_cycle(0, 0);
    chk("repl_older30", 64'(redirect_rob_idx), 64'd30);
    mp_cycle(7'd50, 5'd6, 0);
    idle_cycle(0, 0);
    chk("repl_younger_kept", 64'(redirect_rob_idx), 64'd30);
    chk("repl_still_pend", 64'(redirect_valid), 64'd1);
    idle_cycle(0, 1);

    // Ready and new b2 together
    mp_cycle(7'd20, 5'd7, 0);
    idle_cycle(0, 0);
    mp_cycle(7'd60, 5'd8, 0);
    idle_cycle(1, 0);
    chk("ready_reload_valid", 64'(redirect_valid), 64'd1);
    chk("ready_reload_rob", 64'(redirect_rob_idx), 64'd60);

    // Flush while pending and with brinfo valid
    clear_inputs();
    flush = 1;
    set_src(0, 1, 1, 0, 5'd9, 7'd3, 3'd0, 2'd0, 21'd0);
    #1;
    chk("flush_res_mask", 64'(b1_resolve_mask), 64'd0);
    chk("flush_mp_mask", 64'(b1_mispredict_mask), 64'd0);
    cycle();
    chk("flush_b2_valid", 64'(b2_valid), 64'd0);
    chk("flush_redirect_valid", 64'(redirect_valid), 64'd0);

    // Asynchronous reset mid-PEND
    mp_cycle(7'd11, 5'd10, 0);
    mp_cycle(7'd12, 5'd11, 0);
    chk("async_pre_pend", 64'(redirect_valid), 64'd1);
    chk("async_pre_b2", 64'(b2_valid), 64'd1);
    @(posedge clock);
    #2;
    reset = 0;
    #1;
    chk("async_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("async_b2_valid", 64'(b2_valid), 64'd0);
    model_reset();
    @(negedge clock);
    check_regs();
    reset = 1;
    clear_inputs();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      rob_head_idx = 7'($urandom);
      redirect_ready = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        set_src(i, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 19)),
                7'($urandom), 3'($urandom), 2'($urandom), 21'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
